// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and types for the two-port data memory arbiter.
package data_mem_arbiter_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_state_t;

    // Response owed on the cycle after a grant.
    typedef struct packed {
        logic port;
        logic we;
        logic err;
    } pend_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; mask removes a port from contention (used for locks).
module rr_arbiter2
    import data_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);
    logic       rr_last;
    logic [1:0] elig;

    assign elig = req & mask;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        gnt = elig;
        if (elig == 2'b11)
            gnt = (rr_last == PORT1) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_last <= PORT1;
        else if (|gnt)
            rr_last <= gnt[1];
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between P0 (CPU) and P1 (DMA/debug) with
// round-robin fairness, bounded locking and a 1-cycle response pipeline.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int DEPTH    = 201,
    parameter int MAX_LOCK = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              P0_Req,
    input  logic              P0_We,
    input  logic              P0_Lock,
    input  logic [ADDR_W-1:0] P0_Addr,
    input  logic [DATA_W-1:0] P0_Wdata,
    output logic              P0_Gnt,
    output logic              P0_Rvalid,
    output logic [DATA_W-1:0] P0_Rdata,
    output logic              P0_Err,
    input  logic              P1_Req,
    input  logic              P1_We,
    input  logic              P1_Lock,
    input  logic [ADDR_W-1:0] P1_Addr,
    input  logic [DATA_W-1:0] P1_Wdata,
    output logic              P1_Gnt,
    output logic              P1_Rvalid,
    output logic [DATA_W-1:0] P1_Rdata,
    output logic              P1_Err,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Write_Data,
    output logic              Mem_MemWrite,
    input  logic [DATA_W-1:0] Mem_Read_Data
);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [3:0]        MAX_CNT  = 4'(MAX_LOCK);
    localparam bit                CAN_LOCK = (MAX_LOCK > 1);

    lock_state_t       state;
    logic [3:0]        lock_cnt;
    logic [1:0]        mask, gnt;
    logic              any_gnt, win, sel_we, sel_lock, own_lock, sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              pend_vld;
    pend_t             pend;

    always_comb begin
        case (state)
            LOCKED0: mask = 2'b01;
            LOCKED1: mask = 2'b10;
            default: mask = 2'b11;
        endcase
    end

    rr_arbiter2 u_rr (
        .clk  (Clk),
        .rst_n(Rst_n),
        .req  ({P1_Req, P0_Req}),
        .mask (mask),
        .gnt  (gnt)
    );

    assign P0_Gnt    = gnt[0];
    assign P1_Gnt    = gnt[1];
    assign any_gnt   = |gnt;
    assign win       = gnt[1];
    assign sel_addr  = win ? P1_Addr  : P0_Addr;
    assign sel_wdata = win ? P1_Wdata : P0_Wdata;
    assign sel_we    = win ? P1_We    : P0_We;
    assign sel_lock  = win ? P1_Lock  : P0_Lock;
    assign sel_err   = (sel_addr >= DEPTH_A);
    assign own_lock  = (state == LOCKED1) ? P1_Lock : P0_Lock;

    assign Mem_Address    = any_gnt ? sel_addr  : '0;
    assign Mem_Write_Data = any_gnt ? sel_wdata : '0;
    assign Mem_MemWrite   = any_gnt & sel_we & ~sel_err;

    // Lock counts every cycle while held; releasing with the owner idle is allowed.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (any_gnt && sel_lock && CAN_LOCK) begin
                        state    <= win ? LOCKED1 : LOCKED0;
                        lock_cnt <= 4'd1;
                    end
                end
                LOCKED0, LOCKED1: begin
                    if (!own_lock || (lock_cnt + 4'd1 >= MAX_CNT)) begin
                        state    <= UNLOCKED;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_vld <= 1'b0;
            pend     <= '0;
        end else begin
            pend_vld <= any_gnt;
            pend     <= '{port: win, we: sel_we, err: sel_err};
        end
    end

    assign P0_Rvalid = pend_vld & (pend.port == PORT0);
    assign P1_Rvalid = pend_vld & (pend.port == PORT1);
    assign P0_Err    = P0_Rvalid & pend.err;
    assign P1_Err    = P1_Rvalid & pend.err;
    assign P0_Rdata  = (P0_Rvalid & ~pend.we & ~pend.err) ? Mem_Read_Data : '0;
    assign P1_Rdata  = (P1_Rvalid & ~pend.we & ~pend.err) ? Mem_Read_Data : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Vector-table bench for data_mem_arbiter with a behavioural memory and response scoreboard.
module tb_data_mem_arbiter;
    localparam int DEPTH = 201;

    typedef struct {
        logic        r0, we0, lk0;
        logic [15:0] a0, d0;
        logic        r1, we1, lk1;
        logic [15:0] a1, d1;
        logic [1:0]  gnt;
        logic        mw;
    } vec_t;

    typedef struct {
        logic        port;
        logic [15:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 0, rst_n = 0, load = 1;
    logic        p0_req = 0, p0_we = 0, p0_lock = 0, p1_req = 0, p1_we = 0, p1_lock = 0;
    logic [15:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_we;
    logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    resp_t       sb[$];
    vec_t        vecs[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DEPTH(DEPTH), .MAX_LOCK(4)) dut (
        .Clk(clk), .Rst_n(rst_n),
        .P0_Req(p0_req), .P0_We(p0_we), .P0_Lock(p0_lock), .P0_Addr(p0_addr), .P0_Wdata(p0_wdata),
        .P0_Gnt(p0_gnt), .P0_Rvalid(p0_rvalid), .P0_Rdata(p0_rdata), .P0_Err(p0_err),
        .P1_Req(p1_req), .P1_We(p1_we), .P1_Lock(p1_lock), .P1_Addr(p1_addr), .P1_Wdata(p1_wdata),
        .P1_Gnt(p1_gnt), .P1_Rvalid(p1_rvalid), .P1_Rdata(p1_rdata), .P1_Err(p1_err),
        .Mem_Address(mem_addr), .Mem_Write_Data(mem_wdata), .Mem_MemWrite(mem_we),
        .Mem_Read_Data(mem_rdata)
    );

    function automatic logic [15:0] image(int i);
        case (i)
            0: return 16'd3;
            1: return 16'd4;
            2: return 16'd1;
            3: return 16'd2;
            default: return 16'h1000 + 16'(i);
        endcase
    endfunction

    // Synchronous single-port memory with the init image loaded while load is high.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= image(i);
        end else begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(logic r0, we0, lk0, logic [15:0] a0, d0,
                               logic r1, we1, lk1, logic [15:0] a1, d1,
                               logic [1:0] gnt, logic mw);
        vec_t x;
        x.r0 = r0; x.we0 = we0; x.lk0 = lk0; x.a0 = a0; x.d0 = d0;
        x.r1 = r1; x.we1 = we1; x.lk1 = lk1; x.a1 = a1; x.d1 = d1;
        x.gnt = gnt; x.mw = mw;
        return x;
    endfunction

    task automatic check_resp();
        resp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rvalid", {30'd0, p1_rvalid, p0_rvalid}, e.port ? 32'd2 : 32'd1);
            chk("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
            chk("err", e.port ? p1_err : p0_err, e.err);
        end else begin
            chk("rvalid_idle", {30'd0, p1_rvalid, p0_rvalid}, 0);
        end
    endtask

    task automatic step(vec_t x);
        resp_t       e;
        logic [15:0] a, d;
        logic        we;
        p0_req = x.r0; p0_we = x.we0; p0_lock = x.lk0; p0_addr = x.a0; p0_wdata = x.d0;
        p1_req = x.r1; p1_we = x.we1; p1_lock = x.lk1; p1_addr = x.a1; p1_wdata = x.d1;
        @(negedge clk);
        check_resp();
        chk("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, x.gnt});
        chk("mem_we", mem_we, x.mw);
        a  = x.gnt[1] ? x.a1 : x.a0;
        d  = x.gnt[1] ? x.d1 : x.d0;
        we = x.gnt[1] ? x.we1 : x.we0;
        chk("mem_addr", mem_addr, (x.gnt != 0) ? a : 16'd0);
        if (x.gnt != 0) begin
            e.port  = x.gnt[1];
            e.err   = (a >= DEPTH);
            e.rdata = (!we && !e.err) ? ref_mem[a[7:0]] : 16'd0;
            if (we && !e.err) ref_mem[a[7:0]] = d;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t idle;
        for (int i = 0; i < 256; i++) ref_mem[i] = image(i);
        idle = v(0,0,0,0,0, 0,0,0,0,0, 2'b00, 0);

        vecs.push_back(v(1,0,0,16'd1,0,      0,0,0,0,0,                2'b01, 0));
        vecs.push_back(idle);
        vecs.push_back(v(0,0,0,0,0,          1,1,0,16'd10,16'hBEEF,    2'b10, 1));
        vecs.push_back(v(0,0,0,0,0,          1,0,0,16'd10,0,           2'b10, 0));
        vecs.push_back(idle);
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(1,0,0,16'd0,0,  1,0,0,16'd2,0, (i % 2 == 0) ? 2'b01 : 2'b10, 0));
        vecs.push_back(idle);
        vecs.push_back(v(0,0,0,0,0,          1,1,0,16'd201,16'hDEAD,   2'b10, 0));
        vecs.push_back(idle);
        vecs.push_back(v(1,0,0,16'd300,0,    0,0,0,0,0,                2'b01, 0));
        vecs.push_back(idle);
        vecs.push_back(v(0,0,0,0,0,          1,0,0,16'd3,0,            2'b10, 0));
        // Lock held to expiry against a contending P1.
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(1,0,1,16'd5,0,  1,0,0,16'd6,0,            2'b01, 0));
        vecs.push_back(v(1,0,1,16'd5,0,      1,0,0,16'd6,0,            2'b10, 0));
        vecs.push_back(idle);
        // Owner idles while locked, then releases with Req=0.
        vecs.push_back(v(1,0,1,16'd7,0,      1,0,0,16'd8,0,            2'b01, 0));
        vecs.push_back(v(0,0,1,0,0,          1,0,0,16'd8,0,            2'b00, 0));
        vecs.push_back(v(0,0,0,0,0,          1,0,0,16'd8,0,            2'b00, 0));
        vecs.push_back(v(0,0,0,0,0,          1,0,0,16'd8,0,            2'b10, 0));
        // Release at a grant: that grant still goes to the owner.
        vecs.push_back(v(1,1,1,16'd12,16'h1234, 0,0,0,0,0,             2'b01, 1));
        vecs.push_back(v(1,0,0,16'd12,0,     1,0,0,16'd8,0,            2'b01, 0));
        vecs.push_back(v(1,0,0,16'd0,0,      1,0,0,16'd9,0,            2'b10, 0));
        vecs.push_back(idle);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we,
                           |p0_rdata, |p1_rdata, |mem_addr, |mem_wdata}, 0);
        load = 0;
        @(posedge clk); #1;
        rst_n = 1;

        foreach (vecs[i]) step(vecs[i]);

        chk("mem200_kept", mem[200], image(200));
        chk("mem10_written", mem[10], 16'hBEEF);

        // Reset in the cycle after a P0 read grant drops the response and restores rr_last.
        step(v(1,0,0,16'd2,0, 0,0,0,0,0, 2'b01, 0));
        void'(sb.pop_back());
        rst_n = 0;
        p0_req = 0; p1_req = 0;
        @(negedge clk);
        chk("rst_no_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 0);
        chk("rst_outs", {p0_gnt, p1_gnt, p0_err, p1_err, mem_we, |p0_rdata, |p1_rdata, |mem_addr}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        step(v(1,0,0,16'd1,0, 1,0,0,16'd3,0, 2'b01, 0));
        step(idle);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
